// File: rtl/cpu5_ifu_pkg.sv
// Shared constants, state codes and types for the cpu5 instruction fetch unit.
// The fetch buffer entry pairs an instruction word with its fetch address.
package cpu5_ifu_pkg;

  localparam int CPU5_OPCODE_SIZE = 6;
  localparam int CPU5_ADDR_SIZE   = 32;
  localparam int CPU5_INST_SIZE   = 32;
  localparam int CPU5_IFU_DEPTH   = 2;

  localparam logic [CPU5_ADDR_SIZE-1:0] CPU5_DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] CPU5_IFU_ST_IDLE = 2'd0;
  localparam logic [1:0] CPU5_IFU_ST_REQ  = 2'd1;
  localparam logic [1:0] CPU5_IFU_ST_DROP = 2'd2;

  typedef enum logic [1:0] {
    IFU_IDLE = CPU5_IFU_ST_IDLE,
    IFU_REQ  = CPU5_IFU_ST_REQ,
    IFU_DROP = CPU5_IFU_ST_DROP
  } ifu_state_e;

  typedef struct packed {
    logic [CPU5_ADDR_SIZE-1:0] pc;
    logic [CPU5_INST_SIZE-1:0] inst;
  } ifu_entry_t;

  function automatic logic [CPU5_ADDR_SIZE-1:0] pc_plus4(input logic [CPU5_ADDR_SIZE-1:0] pc);
    return pc + CPU5_ADDR_SIZE'(4);
  endfunction

endpackage

// File: rtl/cpu5_ifu_fifo.sv
// Two-entry {pc, inst} fetch buffer; flush wins over push and pop.
// Head entry is presented combinationally from the read pointer.
module cpu5_ifu_fifo
  import cpu5_ifu_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  ifu_entry_t push_entry,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output ifu_entry_t head
);

  ifu_entry_t                mem_reg [CPU5_IFU_DEPTH];
  logic                      rd_ptr_reg;
  logic                      wr_ptr_reg;
  logic [1:0]                count_reg;
  logic                      do_push;
  logic                      do_pop;
  logic [CPU5_IFU_DEPTH-1:0] wr_en;

  assign do_pop  = pop && (count_reg != 2'd0);
  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  genvar gi;
  for (gi = 0; gi < CPU5_IFU_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && !flush && (wr_ptr_reg == 1'(gi));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CPU5_IFU_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < CPU5_IFU_DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
    end
  end

  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/cpu5_ifu.sv
// cpu5 instruction fetch unit: single-outstanding fetch FSM feeding a two-entry
// buffer towards decode, with redirect flush and drop of stale responses.
module cpu5_ifu
  import cpu5_ifu_pkg::*;
#(
  parameter logic [CPU5_ADDR_SIZE-1:0] RESET_PC = CPU5_DEFAULT_RESET_PC
) (
  input  logic                        clk,
  input  logic                        resetn,
  output logic                        ifu_imem_req,
  output logic [CPU5_ADDR_SIZE-1:0]   ifu_imem_addr,
  input  logic                        imem_ifu_ack,
  input  logic [CPU5_INST_SIZE-1:0]   imem_ifu_rdata,
  input  logic                        exu_ifu_redirect,
  input  logic [CPU5_ADDR_SIZE-1:0]   exu_ifu_target,
  input  logic                        dec_ifu_stall,
  output logic                        ifu_dec_valid,
  output logic [CPU5_INST_SIZE-1:0]   ifu_dec_inst,
  output logic [CPU5_OPCODE_SIZE-1:0] ifu_dec_op,
  output logic [CPU5_ADDR_SIZE-1:0]   ifu_dec_pc,
  output logic [CPU5_ADDR_SIZE-1:0]   ifu_dec_pcplus4
);

  ifu_state_e                state_reg, state_next;
  logic [CPU5_ADDR_SIZE-1:0] pc_reg, pc_next;
  logic [CPU5_ADDR_SIZE-1:0] drop_addr_reg, drop_addr_next;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_flush;
  logic [1:0]                fifo_count;
  ifu_entry_t                fifo_head;
  ifu_entry_t                push_entry;
  logic [2:0]                occ_after;

  assign fifo_pop   = ifu_dec_valid && !dec_ifu_stall;
  assign push_entry = '{pc: pc_reg, inst: imem_ifu_rdata};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IFU_IDLE;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= RESET_PC;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    fifo_push      = 1'b0;
    fifo_flush     = exu_ifu_redirect;
    ifu_imem_req   = 1'b0;
    ifu_imem_addr  = pc_reg;
    occ_after      = {1'b0, fifo_count} + 3'd1 - {2'b00, fifo_pop};
    case (state_reg)
      IFU_IDLE: begin
        if (exu_ifu_redirect) pc_next = exu_ifu_target;
        else if (fifo_count < 2'd2) state_next = IFU_REQ;
      end
      IFU_REQ: begin
        ifu_imem_req = 1'b1;
        if (exu_ifu_redirect) begin
          pc_next = exu_ifu_target;
          if (imem_ifu_ack) begin
            state_next = IFU_IDLE;
          end else begin
            state_next     = IFU_DROP;
            drop_addr_next = pc_reg;
          end
        end else if (imem_ifu_ack) begin
          fifo_push  = 1'b1;
          pc_next    = pc_plus4(pc_reg);
          state_next = (occ_after < 3'd2) ? IFU_REQ : IFU_IDLE;
        end
      end
      IFU_DROP: begin
        // The stale request keeps its original address until memory answers it.
        ifu_imem_req  = 1'b1;
        ifu_imem_addr = drop_addr_reg;
        if (exu_ifu_redirect) pc_next = exu_ifu_target;
        // An ack retires the stale request even if a newer redirect arrives with it.
        if (imem_ifu_ack) state_next = IFU_IDLE;
      end
      default: state_next = IFU_IDLE;
    endcase
  end

  cpu5_ifu_fifo u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  assign ifu_dec_valid   = (fifo_count != 2'd0);
  assign ifu_dec_inst    = ifu_dec_valid ? fifo_head.inst : '0;
  assign ifu_dec_pc      = ifu_dec_valid ? fifo_head.pc : '0;
  assign ifu_dec_pcplus4 = ifu_dec_valid ? pc_plus4(fifo_head.pc) : '0;
  assign ifu_dec_op      = ifu_dec_inst[CPU5_INST_SIZE-1 -: CPU5_OPCODE_SIZE];

endmodule

// File: tb/tb_cpu5_ifu.sv
// Bench for cpu5_ifu: latency-configurable memory model plus a program-order
// scoreboard of what decode receives, with directed and random phases.
module tb_cpu5_ifu;

  localparam logic [31:0] TB_RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        resetn;
  logic        ifu_imem_req;
  logic [31:0] ifu_imem_addr;
  logic        imem_ifu_ack;
  logic [31:0] imem_ifu_rdata;
  logic        exu_ifu_redirect;
  logic [31:0] exu_ifu_target;
  logic        dec_ifu_stall;
  logic        ifu_dec_valid;
  logic [31:0] ifu_dec_inst;
  logic [5:0]  ifu_dec_op;
  logic [31:0] ifu_dec_pc;
  logic [31:0] ifu_dec_pcplus4;

  cpu5_ifu #(.RESET_PC(TB_RESET_PC)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ifu_imem_req     (ifu_imem_req),
    .ifu_imem_addr    (ifu_imem_addr),
    .imem_ifu_ack     (imem_ifu_ack),
    .imem_ifu_rdata   (imem_ifu_rdata),
    .exu_ifu_redirect (exu_ifu_redirect),
    .exu_ifu_target   (exu_ifu_target),
    .dec_ifu_stall    (dec_ifu_stall),
    .ifu_dec_valid    (ifu_dec_valid),
    .ifu_dec_inst     (ifu_dec_inst),
    .ifu_dec_op       (ifu_dec_op),
    .ifu_dec_pc       (ifu_dec_pc),
    .ifu_dec_pcplus4  (ifu_dec_pcplus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] data_key = 32'h0;
  int          lat_min  = 0;
  int          lat_max  = 0;
  logic        inject_ack = 1'b0;
  logic [31:0] exp_pc;
  logic        expect_empty = 1'b0;
  int          consumed = 0;
  logic [31:0] last_pc = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ data_key;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory: answers each request after a latency drawn when the request starts.
  initial begin : mem_model
    int          wait_cnt;
    int          cur_lat;
    logic        pending;
    logic [31:0] prev_addr;
    wait_cnt = 0;
    cur_lat = 0;
    pending = 1'b0;
    prev_addr = 32'h0;
    imem_ifu_ack = 1'b0;
    imem_ifu_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      imem_ifu_ack = 1'b0;
      if (!resetn) begin
        wait_cnt = 0;
        pending = 1'b0;
      end else if (inject_ack && !ifu_imem_req) begin
        imem_ifu_ack = 1'b1;
        imem_ifu_rdata = 32'hDEAD_BEEF;
        inject_ack = 1'b0;
      end else if (ifu_imem_req) begin
        if (pending) check_eq("addr_stable", ifu_imem_addr, prev_addr);
        if (wait_cnt == 0) cur_lat = int'($urandom_range(lat_max, lat_min));
        if (wait_cnt >= cur_lat) begin
          imem_ifu_ack = 1'b1;
          imem_ifu_rdata = mem_data(ifu_imem_addr);
          wait_cnt = 0;
          pending = 1'b0;
        end else begin
          wait_cnt++;
          pending = 1'b1;
          prev_addr = ifu_imem_addr;
        end
      end else begin
        wait_cnt = 0;
        pending = 1'b0;
      end
    end
  end

  // One cycle: apply decode/exu inputs, score what decode takes, advance to next negedge.
  task automatic cycle(input logic stl, input logic rdr, input logic [31:0] tgt);
    logic [31:0] exp_inst;
    dec_ifu_stall = stl;
    exu_ifu_redirect = rdr;
    exu_ifu_target = tgt;
    if (expect_empty) check_eq("flush_empty", 32'(ifu_dec_valid), 32'h0);
    expect_empty = 1'b0;
    if (ifu_dec_valid && !stl && !rdr) begin
      exp_inst = mem_data(exp_pc);
      check_eq("dec_pc", ifu_dec_pc, exp_pc);
      check_eq("dec_inst", ifu_dec_inst, exp_inst);
      check_eq("dec_pcplus4", ifu_dec_pcplus4, exp_pc + 32'd4);
      check_eq("dec_op", 32'(ifu_dec_op), 32'(exp_inst[31:26]));
      $display("dec  pc=%08h inst=%08h op=%02h", ifu_dec_pc, ifu_dec_inst, ifu_dec_op);
      last_pc = ifu_dec_pc;
      consumed++;
      exp_pc += 32'd4;
    end
    if (rdr) begin
      $display("redirect target=%08h", tgt);
      exp_pc = tgt;
      expect_empty = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wait_req(input logic level, input logic stl, input string tag);
    for (int i = 0; i < 20 && ifu_imem_req != level; i++) cycle(stl, 1'b0, 32'h0);
    check_eq(tag, 32'(ifu_imem_req), 32'(level));
  endtask

  task automatic wait_consume(input string tag);
    int prev;
    prev = consumed;
    for (int i = 0; i < 20 && consumed == prev; i++) cycle(1'b0, 1'b0, 32'h0);
    check_eq(tag, 32'(consumed > prev), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(ifu_imem_req), 32'h0);
    check_eq({tag, "_valid"}, 32'(ifu_dec_valid), 32'h0);
    check_eq({tag, "_inst"}, ifu_dec_inst, 32'h0);
    check_eq({tag, "_pc"}, ifu_dec_pc, 32'h0);
    check_eq({tag, "_pcplus4"}, ifu_dec_pcplus4, 32'h0);
    check_eq({tag, "_op"}, 32'(ifu_dec_op), 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [31:0] old_addr;
    logic [31:0] tgt;
    logic        stl, rdr, seen_wrap, seen_zero_fetch;
    int          prev;

    resetn = 1'b0;
    dec_ifu_stall = 1'b0;
    exu_ifu_redirect = 1'b0;
    exu_ifu_target = 32'h0;
    exp_pc = TB_RESET_PC;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Startup and zero-wait throughput from reset
    resetn = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    check_eq("first_req", 32'(ifu_imem_req), 32'h1);
    check_eq("first_addr", ifu_imem_addr, TB_RESET_PC);
    check_eq("valid_cyc1", 32'(ifu_dec_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_eq("valid_cyc2", 32'(ifu_dec_valid), 32'h1);
    for (int k = 0; k < 6; k++) begin
      check_eq("stream_valid", 32'(ifu_dec_valid), 32'h1);
      cycle(1'b0, 1'b0, 32'h0);
    end

    // Redirect to 0: pc 0,4,8,12 back to back
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check_eq("seq_valid", 32'(ifu_dec_valid), 32'h1);
      check_eq("seq_pc", ifu_dec_pc, 32'(k * 4));
      cycle(1'b0, 1'b0, 32'h0);
    end

    // Slow memory, redirect during the wait: stale data dropped
    wait_req(1'b0, 1'b1, "fill_req_low");
    lat_min = 3;
    lat_max = 3;
    wait_req(1'b1, 1'b0, "drop_req_rise");
    old_addr = ifu_imem_addr;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h100);
    check_eq("drop_req_held", 32'(ifu_imem_req), 32'h1);
    check_eq("drop_addr_held", ifu_imem_addr, old_addr);
    wait_req(1'b0, 1'b0, "drop_req_low");
    wait_req(1'b1, 1'b0, "drop_refetch");
    check_eq("drop_new_addr", ifu_imem_addr, 32'h100);
    wait_consume("drop_consume");
    check_eq("drop_first_pc", last_pc, 32'h100);

    // Held stall: buffer fills, fetch stops, nothing lost after release
    wait_req(1'b0, 1'b1, "stall_fill");
    lat_min = 0;
    lat_max = 0;
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_req_low", 32'(ifu_imem_req), 32'h0);
      check_eq("stall_valid", 32'(ifu_dec_valid), 32'h1);
      cycle(1'b1, 1'b0, 32'h0);
    end
    cycle(1'b0, 1'b0, 32'h0);
    check_eq("release_second", 32'(ifu_dec_valid), 32'h1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect in the same cycle as an ack and a pop
    check_eq("coinc_req", 32'(ifu_imem_req), 32'h1);
    check_eq("coinc_valid", 32'(ifu_dec_valid), 32'h1);
    cycle(1'b0, 1'b1, 32'h2000);
    check_eq("coinc_req_idle", 32'(ifu_imem_req), 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_eq("coinc_req_tgt", 32'(ifu_imem_req), 32'h1);
    check_eq("coinc_addr_tgt", ifu_imem_addr, 32'h2000);
    wait_consume("coinc_consume");
    check_eq("coinc_first_pc", last_pc, 32'h2000);

    // Random stall / redirect / memory latency
    lat_min = 0;
    lat_max = 3;
    for (int blk = 0; blk < 4; blk++) begin
      prev = consumed;
      for (int k = 0; k < 100; k++) begin
        stl = ($urandom_range(0, 9) < 3);
        rdr = ($urandom_range(0, 19) == 0);
        tgt = $urandom();
        tgt[1:0] = 2'b00;
        cycle(stl, rdr, tgt);
      end
      check_eq("progress", 32'(consumed > prev), 32'h1);
    end

    // Reset in the middle of an outstanding request, late ack after release
    lat_min = 3;
    lat_max = 3;
    wait_req(1'b1, 1'b0, "pre_rst_req");
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    data_key = 32'h7000_0000;
    lat_min = 0;
    lat_max = 0;
    expect_empty = 1'b0;
    exp_pc = TB_RESET_PC;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    inject_ack = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    check_eq("rst2_req", 32'(ifu_imem_req), 32'h1);
    check_eq("rst2_addr", ifu_imem_addr, TB_RESET_PC);
    check_eq("rst2_valid_cyc1", 32'(ifu_dec_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_eq("rst2_valid_cyc2", 32'(ifu_dec_valid), 32'h1);
    check_eq("rst2_first_pc", ifu_dec_pc, TB_RESET_PC);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0);

    // Fetch across the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFF0);
    seen_wrap = 1'b0;
    seen_zero_fetch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifu_imem_req && ifu_imem_addr == 32'h0) seen_zero_fetch = 1'b1;
      if (ifu_dec_valid && ifu_dec_pc == 32'hFFFF_FFFC && !seen_wrap) begin
        check_eq("wrap_pcplus4", ifu_dec_pcplus4, 32'h0);
        check_eq("wrap_op", 32'(ifu_dec_op), 32'h23);
        seen_wrap = 1'b1;
      end
      cycle(1'b0, 1'b0, 32'h0);
    end
    check_eq("wrap_seen", 32'(seen_wrap), 32'h1);
    check_eq("wrap_zero_fetch", 32'(seen_zero_fetch), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu5_ifu.md
CPU5_IFU -- requirements
Module: cpu5_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 ifu_imem_req  output  1  instruction-memory read request.
REQ-005 ifu_imem_addr  output  32  word-aligned fetch address; stable while req high and unacked.
REQ-006 imem_ifu_ack  input  1  single-cycle acknowledge; rdata valid same cycle.
REQ-007 imem_ifu_rdata  input  32  fetched instruction word.
REQ-008 exu_ifu_redirect  input  1  branch/jump taken; pulse, one cycle.
REQ-009 exu_ifu_target  input  32  redirect target, word-aligned.
REQ-010 dec_ifu_stall  input  1  decode cannot accept this cycle.
REQ-011 ifu_dec_valid  output  1  ifu_dec_* hold a valid instruction.
REQ-012 ifu_dec_inst  output  32  instruction word.
REQ-013 ifu_dec_op  output  CPU5_OPCODE_SIZE (6)  ifu_dec_inst[31:26], feeds the main decoder op input.
REQ-014 ifu_dec_pc  output  32  address of ifu_dec_inst.
REQ-015 ifu_dec_pcplus4  output  32  ifu_dec_pc + 4, modulo 2^32.

Function
REQ-016 Fetch PC register; increments by 4 on each accepted ack that is not dropped; wraps 32'hFFFF_FFFC -> 0.
REQ-017 FSM states: IDLE, REQ, DROP; encoding in shared defines.
REQ-018 IDLE: req low; -> REQ when buffer count + outstanding < 2 and no redirect this cycle.
REQ-019 REQ: req high, addr = PC; at most one request outstanding.
REQ-020 REQ with ack: push {PC, rdata} into buffer, PC += 4; stay in REQ if space remains after push (count + 1 - pop < 2), else -> IDLE.
REQ-021 Zero-wait memory: ack in the first cycle req is high is legal and handled as in REQ-020.
REQ-022 Redirect in IDLE: flush buffer, PC <= target, stay IDLE; first req to target next cycle.
REQ-023 Redirect in REQ without ack: flush buffer, PC <= target, -> DROP; req remains high with the old address until ack.
REQ-024 DROP: on ack, discard rdata, no push, -> IDLE; req low the cycle after ack.
REQ-025 Redirect in REQ with ack same cycle: acked data discarded, buffer flushed, PC <= target, -> IDLE.
REQ-026 Redirect in DROP: PC <= new target (latest wins); stay DROP.
REQ-027 Instruction buffer: 2-entry FIFO of {pc, inst}; ifu_dec_valid = not empty; outputs driven from head entry, combinationally.
REQ-028 Pop when ifu_dec_valid and not dec_ifu_stall; push and pop in same cycle keep count unchanged.
REQ-029 Redirect has priority over push and pop: flush yields count 0 and ifu_dec_valid low next cycle.
REQ-030 Ack while req low is ignored (flagged by bench assertion).
REQ-031 Throughput: with zero-wait memory and no stall, one instruction per cycle to decode after 2-cycle startup (first valid at cycle 2 after reset release).

Reset
REQ-032 Asserting resetn low: immediately ifu_imem_req 0, ifu_dec_valid 0, FSM IDLE, buffer empty, PC = RESET_PC; ifu_dec_inst/pc/pcplus4/op 0.
REQ-033 Reset mid-transaction abandons the outstanding request; a late ack after reset release arrives with req low and is ignored per REQ-030.
REQ-034 First request issued on the first clock edge after resetn deasserts.

Structure
REQ-035 Shared defines file holds CPU5_OPCODE_SIZE, CPU5_ADDR_SIZE (32), CPU5_INST_SIZE (32), CPU5_IFU_ST_* state codes, default reset PC constant.
REQ-036 One sub-module cpu5_ifu_fifo: 2-entry {pc, inst} buffer with push, pop, flush, count, head outputs.

Verification
REQ-037 Zero-wait memory returning addr as data, no stall -> ifu_dec_pc 0,4,8,12 on consecutive cycles from cycle 2; pcplus4 = pc+4.
REQ-038 Memory ack 3 cycles after req, redirect to 32'h100 in cycle 1 of wait -> old data dropped, next req addr 32'h100, next ifu_dec_pc 32'h100.
REQ-039 Stall held 5 cycles, zero-wait memory -> count saturates at 2, req low while full, no instruction lost or duplicated after release.
REQ-040 Redirect coincident with ack and pop -> buffer empty next cycle, acked word never reaches decode, next fetch = target.
REQ-041 resetn low mid-request with RESET_PC = 32'hBFC0_0000 -> req and valid drop immediately; first post-reset addr 32'hBFC0_0000.
REQ-042 PC 32'hFFFF_FFFC fetched -> pcplus4 0, next fetch addr 0; ifu_dec_op equals inst[31:26] (6'b100011 for lw word).
